// File: rtl/patch_descriptor_engine.sv
`default_nettype none
// ============================================================================
//  Module   : patch_descriptor_engine
//  Brief    : Scans a PATCH_SIZE x PATCH_SIZE gradient window around one
//             keypoint, bins each pixel's orientation into NUM_BINS bins and
//             accumulates saturating per-sub-block histograms, then presents
//             the packed descriptor with a one-cycle valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module patch_descriptor_engine #(
  parameter int DIMENSION    = 64,
  parameter int BIT_DEPTH    = 8,
  parameter int PATCH_SIZE   = 4,
  parameter int SUB_SIZE     = 2,
  parameter int NUM_BINS     = 8,
  parameter int READ_LATENCY = 2,
  parameter int BIN_WIDTH    = $clog2(SUB_SIZE * SUB_SIZE) + 1,
  localparam int NSUB = (PATCH_SIZE / SUB_SIZE) * (PATCH_SIZE / SUB_SIZE),
  localparam int AW   = $clog2(DIMENSION * DIMENSION),
  localparam int CW   = $clog2(DIMENSION),
  localparam int DW   = NSUB * NUM_BINS * BIN_WIDTH
) (
  input  logic                        clk_in,
  input  logic                        rst_in_n,
  input  logic                        start,
  input  logic [CW-1:0]               key_x,
  input  logic [CW-1:0]               key_y,
  output logic [AW-1:0]               grad_addr,
  input  logic signed [BIT_DEPTH-1:0] x_grad,
  input  logic signed [BIT_DEPTH-1:0] y_grad,
  output logic                        busy,
  output logic [DW-1:0]               desc_out,
  output logic                        desc_valid
);

  localparam int HALF = PATCH_SIZE / 2;
  localparam int NSB  = PATCH_SIZE / SUB_SIZE;
  localparam int PW   = (PATCH_SIZE > 2) ? $clog2(PATCH_SIZE) : 1;
  localparam int SW   = (NSUB > 1) ? $clog2(NSUB) : 1;
  localparam int BW   = $clog2(NUM_BINS);
  localparam int DCW  = $clog2(READ_LATENCY + 2);
  localparam int MW   = BIT_DEPTH + 1;
  localparam int NCNT = NSUB * NUM_BINS;

  localparam logic [PW-1:0]  LAST_IDX   = PW'(PATCH_SIZE - 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(READ_LATENCY);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SCAN  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]     state_q, state_d;
  logic [CW-1:0]  key_x_q, key_x_d;
  logic [CW-1:0]  key_y_q, key_y_d;
  logic [PW-1:0]  row_q, row_d;
  logic [PW-1:0]  col_q, col_d;
  logic [DCW-1:0] drain_q, drain_d;
  logic [AW-1:0]  addr_hold_q, addr_hold_d;

  // Tag pipeline travels alongside the BRAM read so each returning gradient
  // knows whether it is real and which sub-block it belongs to.
  logic           tag_vld_q [READ_LATENCY];
  logic           tag_vld_d [READ_LATENCY];
  logic [SW-1:0]  tag_sub_q [READ_LATENCY];
  logic [SW-1:0]  tag_sub_d [READ_LATENCY];

  logic           bin_vld_q, bin_vld_d;
  logic [SW-1:0]  bin_sub_q, bin_sub_d;
  logic [BW-1:0]  bin_idx_q, bin_idx_d;

  logic [BIN_WIDTH-1:0] bins_q [NCNT];
  logic [BIN_WIDTH-1:0] bins_d [NCNT];

  logic           accept;
  logic           last_pix;
  logic [CW+1:0]  px, py;
  logic           pix_in;
  logic [AW-1:0]  pix_addr;
  logic [SW-1:0]  pix_sub;

  logic [MW-1:0]  gx_ext, gy_ext, gx_mag, gy_mag;
  logic           gx_neg, gy_neg, gx_zero, gy_zero, gx_pos, gy_pos;
  logic [1:0]     quad;
  logic           half;
  logic           grad_zero;
  logic [BW-1:0]  bin_sel;

  assign accept   = (state_q == S_IDLE) && start;
  assign last_pix = (row_q == LAST_IDX) && (col_q == LAST_IDX);

  // Window pixel position, kept two bits wider so off-image pixels show up as
  // a non-zero top field (negative or >= DIMENSION).
  assign px       = {2'b00, key_x_q} + (CW+2)'(col_q) - (CW+2)'(HALF);
  assign py       = {2'b00, key_y_q} + (CW+2)'(row_q) - (CW+2)'(HALF);
  assign pix_in   = (px[CW+1:CW] == 2'b00) && (py[CW+1:CW] == 2'b00);
  assign pix_addr = {py[CW-1:0], px[CW-1:0]};
  assign pix_sub  = SW'((int'(row_q) / SUB_SIZE) * NSB + int'(col_q) / SUB_SIZE);

  // State register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed-length scan, drain, then a single done cycle
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_SCAN;
      S_SCAN:  if (last_pix) state_d = S_DRAIN;
      S_DRAIN: if (drain_q == DRAIN_LAST) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode; off-image pixels leave the address bus at its last value
  always_comb begin
    busy       = (state_q != S_IDLE);
    desc_valid = (state_q == S_DONE);
    grad_addr  = addr_hold_q;
    if ((state_q == S_SCAN) && pix_in) begin
      grad_addr = pix_addr;
    end
  end

  // Keypoint latch, raster counters, drain counter and address hold
  always_comb begin
    key_x_d     = key_x_q;
    key_y_d     = key_y_q;
    row_d       = row_q;
    col_d       = col_q;
    addr_hold_d = addr_hold_q;
    drain_d     = (state_q == S_DRAIN) ? drain_q + 1'b1 : '0;
    if (accept) begin
      key_x_d = key_x;
      key_y_d = key_y;
      row_d   = '0;
      col_d   = '0;
    end
    if (state_q == S_SCAN) begin
      if (pix_in) begin
        addr_hold_d = pix_addr;
      end
      if (col_q == LAST_IDX) begin
        col_d = '0;
        row_d = row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  // Tag shift register matched to the BRAM read latency
  always_comb begin
    tag_vld_d[0] = (state_q == S_SCAN) && pix_in;
    tag_sub_d[0] = pix_sub;
    for (int k = 1; k < READ_LATENCY; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_sub_d[k] = tag_sub_q[k-1];
    end
  end

  // Magnitudes use one extra bit so the most negative gradient is exact
  assign gx_neg  = x_grad[BIT_DEPTH-1];
  assign gy_neg  = y_grad[BIT_DEPTH-1];
  assign gx_zero = (x_grad == '0);
  assign gy_zero = (y_grad == '0);
  assign gx_pos  = !gx_neg && !gx_zero;
  assign gy_pos  = !gy_neg && !gy_zero;
  assign gx_ext  = {x_grad[BIT_DEPTH-1], x_grad};
  assign gy_ext  = {y_grad[BIT_DEPTH-1], y_grad};
  assign gx_mag  = gx_neg ? (~gx_ext + MW'(1)) : gx_ext;
  assign gy_mag  = gy_neg ? (~gy_ext + MW'(1)) : gy_ext;

  // Orientation: quadrant from signs, then which side of the diagonal
  always_comb begin
    grad_zero = gx_zero && gy_zero;
    if (gx_pos && !gy_neg) begin
      quad = 2'd0;
    end else if (!gx_pos && gy_pos) begin
      quad = 2'd1;
    end else if (gx_neg && !gy_pos) begin
      quad = 2'd2;
    end else begin
      quad = 2'd3;
    end
    half = quad[0] ? (gx_mag > gy_mag) : (gy_mag > gx_mag);
  end

  generate
    if (NUM_BINS == 8) begin : g_bins8
      assign bin_sel = {quad, half};
    end else begin : g_bins4
      assign bin_sel = quad;
    end
  endgenerate

  // Binning stage input: a zero gradient never reaches the histogram
  always_comb begin
    bin_vld_d = tag_vld_q[READ_LATENCY-1] && !grad_zero;
    bin_sub_d = tag_sub_q[READ_LATENCY-1];
    bin_idx_d = bin_sel;
  end

  // Histogram update: clear on accepted start, saturating increment otherwise
  always_comb begin
    int acc_idx;
    acc_idx = int'(bin_sub_q) * NUM_BINS + int'(bin_idx_q);
    for (int n = 0; n < NCNT; n++) begin
      bins_d[n] = bins_q[n];
      if (accept) begin
        bins_d[n] = '0;
      end else if (bin_vld_q && (n == acc_idx) && (bins_q[n] != '1)) begin
        bins_d[n] = bins_q[n] + 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      key_x_q     <= '0;
      key_y_q     <= '0;
      row_q       <= '0;
      col_q       <= '0;
      drain_q     <= '0;
      addr_hold_q <= '0;
      bin_vld_q   <= 1'b0;
      bin_sub_q   <= '0;
      bin_idx_q   <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        tag_vld_q[k] <= 1'b0;
        tag_sub_q[k] <= '0;
      end
      for (int n = 0; n < NCNT; n++) begin
        bins_q[n] <= '0;
      end
    end else begin
      key_x_q     <= key_x_d;
      key_y_q     <= key_y_d;
      row_q       <= row_d;
      col_q       <= col_d;
      drain_q     <= drain_d;
      addr_hold_q <= addr_hold_d;
      bin_vld_q   <= bin_vld_d;
      bin_sub_q   <= bin_sub_d;
      bin_idx_q   <= bin_idx_d;
      tag_vld_q   <= tag_vld_d;
      tag_sub_q   <= tag_sub_d;
      bins_q      <= bins_d;
    end
  end

  generate
    for (genvar n = 0; n < NCNT; n++) begin : g_pack
      assign desc_out[n*BIN_WIDTH +: BIN_WIDTH] = bins_q[n];
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_patch_descriptor_engine.sv
`default_nettype none
// ============================================================================
//  Module   : tb_patch_descriptor_engine
//  Brief    : Scoreboard bench for patch_descriptor_engine. Two instances
//             (8-bin default and 4-bin / 2-bit counters) share a gradient
//             image; expected descriptors come from a window-level model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_patch_descriptor_engine;

  localparam int DIM = 64;
  localparam int CW  = 6;
  localparam int AW  = 12;
  localparam int DW8 = 96;
  localparam int DW4 = 32;

  typedef struct {
    logic [95:0] d;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_in_n;
  logic              start;
  logic [CW-1:0]     key_x, key_y;
  logic [AW-1:0]     addr8, addr4, a8_q, a4_q;
  logic signed [7:0] xg8, yg8, xg4, yg4;
  logic              busy8, busy4, dv8, dv4;
  logic [DW8-1:0]    desc8;
  logic [DW4-1:0]    desc4;

  byte  xmem [DIM*DIM];
  byte  ymem [DIM*DIM];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q8[$];
  exp_t q4[$];

  patch_descriptor_engine dut8 (
    .clk_in(clk), .rst_in_n(rst_in_n), .start(start),
    .key_x(key_x), .key_y(key_y), .grad_addr(addr8),
    .x_grad(xg8), .y_grad(yg8), .busy(busy8),
    .desc_out(desc8), .desc_valid(dv8)
  );

  patch_descriptor_engine #(.NUM_BINS(4), .BIN_WIDTH(2)) dut4 (
    .clk_in(clk), .rst_in_n(rst_in_n), .start(start),
    .key_x(key_x), .key_y(key_y), .grad_addr(addr4),
    .x_grad(xg4), .y_grad(yg4), .busy(busy4),
    .desc_out(desc4), .desc_valid(dv4)
  );

  // Two-cycle BRAM models plus the cycle counter
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    a8_q <= addr8;
    a4_q <= addr4;
    xg8  <= xmem[a8_q];
    yg8  <= ymem[a8_q];
    xg4  <= xmem[a4_q];
    yg4  <= ymem[a4_q];
  end

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] req);
    n_chk++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  // Orientation bin straight from the sign/magnitude rules; -1 means no bin
  function automatic int bin_of(input int gx, input int gy, input int nb);
    int ax, ay, q, h;
    ax = (gx < 0) ? -gx : gx;
    ay = (gy < 0) ? -gy : gy;
    if (gx == 0 && gy == 0) return -1;
    if (gx > 0 && gy >= 0)      q = 0;
    else if (gx <= 0 && gy > 0) q = 1;
    else if (gx < 0 && gy <= 0) q = 2;
    else                        q = 3;
    if (nb == 4) return q;
    if (q == 0 || q == 2) h = (ay > ax) ? 1 : 0;
    else                  h = (ax > ay) ? 1 : 0;
    return 2 * q + h;
  endfunction

  // Whole-window histogram for a keypoint over the current image
  function automatic logic [95:0] model(input int kx, input int ky, input int nb, input int bw);
    int cnt [4][8];
    int lim, px, py, b, s;
    logic [95:0] r;
    r   = '0;
    lim = (1 << bw) - 1;
    for (int s2 = 0; s2 < 4; s2++)
      for (int b2 = 0; b2 < 8; b2++) cnt[s2][b2] = 0;
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        px = kx - 2 + j;
        py = ky - 2 + i;
        if (px >= 0 && px < DIM && py >= 0 && py < DIM) begin
          b = bin_of(int'(xmem[py*DIM+px]), int'(ymem[py*DIM+px]), nb);
          s = (i / 2) * 2 + j / 2;
          if (b >= 0 && cnt[s][b] < lim) cnt[s][b]++;
        end
      end
    end
    for (int s2 = 0; s2 < 4; s2++)
      for (int b2 = 0; b2 < nb; b2++)
        for (int k = 0; k < bw; k++)
          r[(s2*nb+b2)*bw+k] = ((cnt[s2][b2] >> k) & 1) != 0;
    return r;
  endfunction

  function automatic byte rg();
    case ($urandom_range(0, 7))
      0:       return 8'sd0;
      1:       return -8'sd128;
      2:       return 8'sd127;
      3:       return byte'(int'($urandom_range(0, 4)) - 2);
      default: return byte'($urandom);
    endcase
  endfunction

  function automatic int rk();
    case ($urandom_range(0, 5))
      0:       return 0;
      1:       return 1;
      2:       return 62;
      3:       return 63;
      default: return int'($urandom_range(0, 63));
    endcase
  endfunction

  task automatic fill_const(input byte gx, input byte gy);
    for (int a = 0; a < DIM*DIM; a++) begin
      xmem[a] = gx;
      ymem[a] = gy;
    end
  endtask

  task automatic fill_rand();
    byte g;
    int  m;
    for (int a = 0; a < DIM*DIM; a++) begin
      g = rg();
      m = int'($urandom_range(0, 5));
      xmem[a] = g;
      ymem[a] = (m == 0) ? g : (m == 1) ? byte'(-g) : rg();
    end
  endtask

  // One descriptor request; expected results go to the scoreboard queues
  task automatic run_op(input int kx, input int ky, input bit poke);
    exp_t e;
    int   t, px, py;
    @(negedge clk);
    start = 1'b1;
    key_x = CW'(kx);
    key_y = CW'(ky);
    @(posedge clk);
    #1 start = 1'b0;
    e.cyc = cyc + 19;
    e.d   = model(kx, ky, 8, 3);
    q8.push_back(e);
    e.d   = model(kx, ky, 4, 2);
    q4.push_back(e);
    for (int p = 0; p < 16; p++) begin
      @(negedge clk);
      if (poke && p == 6) start = 1'b0;
      if (p == 0) chk("busy_scan", {95'd0, busy8}, 96'd1);
      px = kx - 2 + p % 4;
      py = ky - 2 + p / 4;
      if (px >= 0 && px < DIM && py >= 0 && py < DIM) begin
        chk("grad_addr8", 96'(addr8), 96'(py * DIM + px));
        chk("grad_addr4", 96'(addr4), 96'(py * DIM + px));
      end
      if (poke && p == 5) begin
        start = 1'b1;
        key_x = CW'($urandom_range(0, 63));
        key_y = CW'($urandom_range(0, 63));
      end
    end
    t = 0;
    while (busy8 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("op_done", {95'd0, busy8}, 96'd0);
    @(negedge clk);
  endtask

  // Monitor: every valid pulse must match the oldest expected descriptor
  always @(negedge clk) begin
    exp_t e;
    if (dv8) begin
      if (q8.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL desc8_extra: actual=pulse required=no pulse");
      end else begin
        e = q8.pop_front();
        chk("desc8", desc8, e.d);
        chk("lat8", 96'(cyc), 96'(e.cyc));
      end
    end
    if (dv4) begin
      if (q4.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL desc4_extra: actual=pulse required=no pulse");
      end else begin
        e = q4.pop_front();
        chk("desc4", 96'(desc4), e.d);
        chk("lat4", 96'(cyc), 96'(e.cyc));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_in_n = 1'b0;
    start    = 1'b0;
    key_x    = '0;
    key_y    = '0;
    fill_const(8'sd0, 8'sd0);
    repeat (3) @(negedge clk);
    chk("rst_busy8", {95'd0, busy8}, 96'd0);
    chk("rst_dv8",   {95'd0, dv8}, 96'd0);
    chk("rst_desc8", desc8, 96'd0);
    chk("rst_addr8", 96'(addr8), 96'd0);
    chk("rst_busy4", {95'd0, busy4}, 96'd0);
    chk("rst_desc4", 96'(desc4), 96'd0);
    rst_in_n = 1'b1;

    fill_const(8'sd5, 8'sd0);     run_op(10, 10, 1'b0);
    fill_const(8'sd3, 8'sd7);     run_op(0, 0, 1'b0);
    fill_const(-8'sd128, 8'sd0);  run_op(30, 30, 1'b0);
    fill_const(8'sd0, 8'sd0);     run_op(30, 30, 1'b0);
    fill_const(-8'sd1, -8'sd1);   run_op(10, 10, 1'b0);
    fill_rand();                  run_op(20, 20, 1'b1);

    // Reset in the middle of a scan
    fill_const(8'sd5, 8'sd0);
    @(negedge clk);
    start = 1'b1;
    key_x = CW'(20);
    key_y = CW'(33);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("pre_rst_busy", {95'd0, busy8}, 96'd1);
    chk("pre_rst_desc_nonzero", {95'd0, (desc8 != '0)}, 96'd1);
    rst_in_n = 1'b0;
    #1;
    chk("mid_rst_busy8", {95'd0, busy8}, 96'd0);
    chk("mid_rst_dv8",   {95'd0, dv8}, 96'd0);
    chk("mid_rst_desc8", desc8, 96'd0);
    chk("mid_rst_busy4", {95'd0, busy4}, 96'd0);
    chk("mid_rst_desc4", 96'(desc4), 96'd0);
    @(negedge clk);
    rst_in_n = 1'b1;
    fill_rand();
    run_op(20, 33, 1'b0);

    repeat (30) begin
      fill_rand();
      run_op(rk(), rk(), ($urandom_range(0, 3) == 0));
    end

    repeat (3) @(negedge clk);
    chk("q8_drained", 96'(q8.size()), 96'd0);
    chk("q4_drained", 96'(q4.size()), 96'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
